// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// ----------------
// Multi-cycle sequencer that turns one decoded instruction opcode into the
// ordered ALUOp step codes the ALU control decoder needs:
//   - LW issues three steps.
//   - SW issues two steps.
//   - Every other opcode issues one step.
//   - Illegal opcodes (19-31) issue a single NOP code.
// MUL/DIV are held in a WAIT phase until the ALU reports completion or
// TIMEOUT cycles expire. Completion is then reported to fetch.
//
// Parameters:
//   TIMEOUT       maximum WAIT cycles for MUL/DIV before a forced abort (>=2)
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   instr_valid   opcode present (accepted only while idle)
//   opcode[4:0]   instruction code
//   hold          pipeline stall, freezes issue sequencing
//   alu_done      MUL/DIV result ready (looked at only while waiting)
//   instr_ready   combinational, high while idle
//   alu_op[5:0]   registered ALUOp code
//   alu_op_valid  registered, alu_op is a live step
//   instr_done    registered one-cycle completion pulse
//   illegal       registered pulse with instr_done for an illegal opcode
//   timeout       registered pulse with instr_done for a MUL/DIV abort
module alu_op_sequencer #(
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [4:0] opcode,
  input  logic       hold,
  input  logic       alu_done,
  output logic       instr_ready,
  output logic [5:0] alu_op,
  output logic       alu_op_valid,
  output logic       instr_done,
  output logic       illegal,
  output logic       timeout
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state, state_n;
  logic [4:0]    op_q, op_n;
  logic [1:0]    step, step_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [5:0]    alu_op_n;
  logic          valid_n, done_n, illegal_n, timeout_n;
  logic          is_last, is_muldiv, is_illegal;

  // ALUOp code for a given opcode and step. LW and SW walk through their
  // own small ranges. The single-step opcodes 2..18 map onto 0x05..0x15,
  // which is a plain offset of 3. Illegal opcodes fall back to NOP.
  function automatic logic [5:0] step_code(input logic [4:0] op,
                                           input logic [1:0] s);
    if (op == 5'd0)
      step_code = {4'd0, s};
    else if (op == 5'd1)
      step_code = 6'd3 + {4'd0, s};
    else if (op <= 5'd18)
      step_code = {1'b0, op} + 6'd3;
    else
      step_code = 6'h15;
  endfunction

  // Decode properties of the latched opcode. The opcode is captured at
  // accept, so these stay stable for the whole instruction.
  always_comb begin
    is_muldiv  = (op_q == 5'd5) || (op_q == 5'd6);
    is_illegal = (op_q >= 5'd19);
    case (op_q)
      5'd0:    is_last = (step == 2'd2);
      5'd1:    is_last = (step == 2'd1);
      default: is_last = (step == 2'd0);
    endcase
  end

  assign instr_ready = (state == IDLE);

  // Next-state and next-output logic.
  // The outputs are registered, so this block computes what they must show
  // in the cycle after the coming edge. Everything defaults to "hold
  // current value". The pulses default to zero.
  always_comb begin
    state_n   = state;
    op_n      = op_q;
    step_n    = step;
    wcnt_n    = wcnt;
    alu_op_n  = alu_op;
    valid_n   = alu_op_valid;
    done_n    = 1'b0;
    illegal_n = 1'b0;
    timeout_n = 1'b0;
    case (state)
      IDLE: begin
        valid_n = 1'b0;
        if (instr_valid) begin
          state_n  = ISSUE;
          op_n     = opcode;
          step_n   = 2'd0;
          alu_op_n = step_code(opcode, 2'd0);
          valid_n  = 1'b1;
        end
      end
      ISSUE: begin
        if (!hold) begin
          if (!is_last) begin
            step_n   = step + 2'd1;
            alu_op_n = step_code(op_q, step + 2'd1);
          end else begin
            valid_n = 1'b0;
            if (is_muldiv) begin
              state_n = WAIT;
              wcnt_n  = '0;
            end else begin
              state_n   = IDLE;
              done_n    = 1'b1;
              illegal_n = is_illegal;
            end
          end
        end
      end
      WAIT: begin
        // alu_done takes priority over an expiring counter.
        valid_n = 1'b0;
        if (alu_done) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (wcnt == WW'(TIMEOUT - 1)) begin
          state_n   = IDLE;
          done_n    = 1'b1;
          timeout_n = 1'b1;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  // A reset mid-instruction drops the instruction without any pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= 5'd0;
      step         <= 2'd0;
      wcnt         <= '0;
      alu_op       <= 6'h15;
      alu_op_valid <= 1'b0;
      instr_done   <= 1'b0;
      illegal      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_n;
      op_q         <= op_n;
      step         <= step_n;
      wcnt         <= wcnt_n;
      alu_op       <= alu_op_n;
      alu_op_valid <= valid_n;
      instr_done   <= done_n;
      illegal      <= illegal_n;
      timeout      <= timeout_n;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// -------------------
// Self-checking bench for alu_op_sequencer. The DUT is built with TIMEOUT=4.
// - A queue-based reference model predicts every output, every cycle.
// - A compare process checks the DUT against that model on the falling edge.
// - Directed instruction runs add hand-computed literal checks on:
//   - the issued step codes,
//   - completion latency,
//   - the illegal and timeout pulses.
module tb_alu_op_sequencer;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic       hold = 1'b0;
  logic       alu_done = 1'b0;
  logic       instr_ready;
  logic [5:0] alu_op;
  logic       alu_op_valid, instr_done, illegal, timeout;

  int compared = 0;
  int mismatched = 0;
  bit checking = 1'b0;

  alu_op_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .hold(hold), .alu_done(alu_done), .instr_ready(instr_ready),
    .alu_op(alu_op), .alu_op_valid(alu_op_valid), .instr_done(instr_done),
    .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends, even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: bumps the counters and reports any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model.
  // - An accepted instruction becomes a queue of step codes.
  // - Each un-held issue cycle consumes one code.
  // - MUL/DIV then count WAIT cycles until alu_done or TIMEOUT.
  // Single-step codes come from a table listed straight from the code chart.
  bit [5:0] codeTab [0:18] = '{6'h00, 6'h03, 6'h05, 6'h06, 6'h07, 6'h08,
                               6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                               6'h0F, 6'h10, 6'h11, 6'h12, 6'h13, 6'h14,
                               6'h15};
  bit [5:0] steps[$];
  bit [5:0] mOp = 6'h15;
  bit       mValid = 0, mDone = 0, mIll = 0, mTo = 0, mReady = 1;
  bit       waiting = 0;
  int       waitCycles = 0;
  int       cur = 0;

  always @(posedge clk) begin
    mDone = 0; mIll = 0; mTo = 0;
    if (rst) begin
      steps.delete();
      waiting = 0;
      mOp = 6'h15;
      mValid = 0;
    end else if (waiting) begin
      waitCycles++;
      if (alu_done) begin
        waiting = 0; mDone = 1;
      end else if (waitCycles == TO) begin
        waiting = 0; mDone = 1; mTo = 1;
      end
    end else if (steps.size() > 0) begin
      if (!hold) begin
        void'(steps.pop_front());
        if (steps.size() > 0) mOp = steps[0];
        else begin
          mValid = 0;
          if (cur == 5 || cur == 6) begin
            waiting = 1; waitCycles = 0;
          end else begin
            mDone = 1; mIll = (cur >= 19);
          end
        end
      end
    end else if (instr_valid) begin
      cur = int'(opcode);
      if (cur == 0) begin
        steps.push_back(6'h00); steps.push_back(6'h01); steps.push_back(6'h02);
      end else if (cur == 1) begin
        steps.push_back(6'h03); steps.push_back(6'h04);
      end else if (cur <= 18) steps.push_back(codeTab[cur]);
      else steps.push_back(6'h15);
      mOp = steps[0];
      mValid = 1;
    end
    mReady = !waiting && (steps.size() == 0);
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("cyc_alu_op", alu_op, mOp);
      checkOutput("cyc_valid", alu_op_valid, mValid);
      checkOutput("cyc_done", instr_done, mDone);
      checkOutput("cyc_illegal", illegal, mIll);
      checkOutput("cyc_timeout", timeout, mTo);
      checkOutput("cyc_ready", instr_ready, mReady);
    end
  end

  // Results of the most recent directed instruction.
  int       doneCycle;
  bit       sawIll, sawTo;
  bit [5:0] trace[$];

  // Packs the captured step codes, first step in the low bits.
  function automatic logic [31:0] packTrace();
    logic [31:0] p = '0;
    for (int i = 0; i < trace.size() && i < 5; i++) p |= 32'(trace[i]) << (6 * i);
    return p;
  endfunction

  // Runs one instruction, starting at a falling edge.
  // - The opcode input is scrambled after accept to prove it is latched.
  // - hold is driven for holdLen cycles starting at relative cycle holdStart.
  // - alu_done is driven in relative cycle doneAt.
  // - The bound on waiting for instr_done is 40 cycles.
  task automatic applyStimulus(input logic [4:0] op, input int holdStart,
                               input int holdLen, input int doneAt);
    trace.delete();
    doneCycle = -1; sawIll = 0; sawTo = 0;
    instr_valid = 1'b1;
    opcode = op;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      opcode = ~op;
      if (alu_op_valid) trace.push_back(alu_op);
      if (instr_done) begin
        doneCycle = i; sawIll = illegal; sawTo = timeout;
        break;
      end
      hold = (i >= holdStart) && (i < holdStart + holdLen);
      alu_done = (i == doneAt);
    end
    hold = 1'b0;
    alu_done = 1'b0;
  endtask

  initial begin
    $display("[TB] start, TIMEOUT=%0d", TO);
    // Reset then idle.
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checking = 1'b1;
    checkOutput("rst_alu_op", alu_op, 6'h15);
    checkOutput("rst_valid", alu_op_valid, 1'b0);
    checkOutput("rst_ready", instr_ready, 1'b1);
    checkOutput("rst_pulses", {instr_done, illegal, timeout}, 3'b000);
    repeat (2) @(negedge clk);

    // LW back-to-back with SW: 4 + 3 = 7 cycles.
    applyStimulus(5'd0, 0, 0, 0);
    checkOutput("lw_len", trace.size(), 3);
    checkOutput("lw_trace", packTrace(), {6'h02, 6'h01, 6'h00});
    checkOutput("lw_done_cyc", doneCycle, 4);
    applyStimulus(5'd1, 0, 0, 0);
    checkOutput("sw_trace", packTrace(), {6'h04, 6'h03});
    checkOutput("sw_done_cyc", doneCycle, 3);

    // Hold for 2 cycles while LW shows 0x01.
    @(negedge clk);
    applyStimulus(5'd0, 2, 2, 0);
    checkOutput("lwh_len", trace.size(), 5);
    checkOutput("lwh_trace", packTrace(), {6'h02, 6'h01, 6'h01, 6'h01, 6'h00});
    checkOutput("lwh_done_cyc", doneCycle, 6);

    // DIV completing in WAIT cycle 2 (third WAIT cycle).
    applyStimulus(5'd6, 0, 0, 4);
    checkOutput("div_trace", packTrace(), 32'h09);
    checkOutput("div_done_cyc", doneCycle, 5);
    checkOutput("div_to", sawTo, 1'b0);
    checkOutput("div_op_hold", alu_op, 6'h09);

    // DIV without alu_done: timeout after exactly 4 WAIT cycles.
    applyStimulus(5'd6, 0, 0, 0);
    checkOutput("divto_done_cyc", doneCycle, 6);
    checkOutput("divto_to", sawTo, 1'b1);

    // DIV with alu_done in the last WAIT cycle: alu_done beats timeout.
    applyStimulus(5'd6, 0, 0, 5);
    checkOutput("divlast_done_cyc", doneCycle, 6);
    checkOutput("divlast_to", sawTo, 1'b0);

    // MUL with alu_done only during ISSUE: ignored, so it times out.
    applyStimulus(5'd5, 0, 0, 1);
    checkOutput("mul_trace", packTrace(), 32'h08);
    checkOutput("mul_done_cyc", doneCycle, 6);
    checkOutput("mul_to", sawTo, 1'b1);

    // Illegal opcode.
    applyStimulus(5'd25, 0, 0, 0);
    checkOutput("ill_trace", packTrace(), 32'h15);
    checkOutput("ill_done_cyc", doneCycle, 2);
    checkOutput("ill_flag", sawIll, 1'b1);

    // A few single-step opcodes: ADD, CALL, NOP (legal, so no illegal flag).
    applyStimulus(5'd3, 0, 0, 0);
    checkOutput("add_trace", packTrace(), 32'h06);
    checkOutput("add_done_cyc", doneCycle, 2);
    applyStimulus(5'd16, 0, 0, 0);
    checkOutput("call_trace", packTrace(), 32'h13);
    applyStimulus(5'd18, 0, 0, 0);
    checkOutput("nop_trace", packTrace(), 32'h15);
    checkOutput("nop_ill", sawIll, 1'b0);

    // Reset mid-LW while 0x01 is showing.
    @(negedge clk);
    instr_valid = 1'b1; opcode = 5'd0;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    checkOutput("rlw_pre_op", alu_op, 6'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rlw_op", alu_op, 6'h15);
    checkOutput("rlw_valid", alu_op_valid, 1'b0);
    checkOutput("rlw_ready", instr_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rlw_no_done", instr_done, 1'b0);
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
